// File: rtl/ram_mover_pkg.sv
// Shared types for the RAM mover: command op codes, FSM state encodings
// and default widths.
package ram_mover_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int LW_DEF = 8;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_COPY  = 2'd2,
    OP_FILL  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_WR    = 3'd2,
    S_CP_RD = 3'd3,
    S_CP_WR = 3'd4,
    S_FL_WR = 3'd5,
    S_DONE  = 3'd6
  } state_e;

endpackage

// File: rtl/ram_mover.sv
// Command sequencer in front of a single-port RAM: single read/write,
// ascending block copy and block fill, one command at a time.
//
// state   | meaning
// IDLE    | ready for a command
// RD      | read strobe low, capture mem_rdata at cycle end
// WR      | write strobe low, RAM writes at cycle end
// CP_RD   | copy: read source byte into the write-data register
// CP_WR   | copy: write buffered byte to destination, advance pointers
// FL_WR   | fill: write constant, advance address, one byte per cycle
// DONE    | done pulse, back to IDLE
module ram_mover
  import ram_mover_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_dst,
  input  logic [DW-1:0] req_data,
  input  logic [LW-1:0] req_len,
  output logic          done,
  output logic [DW-1:0] rd_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_rd_,
  output logic          mem_wr_
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic          done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      mem_rd_q    <= 1'b1;
      mem_wr_q    <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      dst_q       <= dst_d;
      rem_q       <= rem_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      done_q      <= done_d;
    end
  end

  // Strobes, address and data are registered, so each branch programs the
  // values that the RAM will see during the state being entered.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;
    mem_rd_d    = 1'b1;
    mem_wr_d    = 1'b1;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          dst_d  = req_dst;
          rem_d  = req_len;
          unique case (op_e'(req_op))
            OP_READ: begin
              state_d    = S_RD;
              mem_rd_d   = 1'b0;
              mem_addr_d = req_addr;
            end
            OP_WRITE: begin
              state_d     = S_WR;
              mem_wr_d    = 1'b0;
              mem_addr_d  = req_addr;
              mem_wdata_d = req_data;
            end
            OP_COPY: begin
              if (req_len == '0) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end else begin
                state_d    = S_CP_RD;
                mem_rd_d   = 1'b0;
                mem_addr_d = req_addr;
              end
            end
            OP_FILL: begin
              if (req_len == '0) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end else begin
                state_d     = S_FL_WR;
                mem_wr_d    = 1'b0;
                mem_addr_d  = req_addr;
                mem_wdata_d = req_data;
              end
            end
            default: ;
          endcase
        end
      end
      S_RD: begin
        rd_data_d = mem_rdata;
        state_d   = S_DONE;
        done_d    = 1'b1;
      end
      S_WR: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_CP_RD: begin
        // mem_wdata doubles as the copy byte buffer
        state_d     = S_CP_WR;
        mem_wr_d    = 1'b0;
        mem_addr_d  = dst_q;
        mem_wdata_d = mem_rdata;
      end
      S_CP_WR: begin
        addr_d = addr_q + 1'b1;
        dst_d  = dst_q + 1'b1;
        rem_d  = rem_q - 1'b1;
        if (rem_d == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d    = S_CP_RD;
          mem_rd_d   = 1'b0;
          mem_addr_d = addr_d;
        end
      end
      S_FL_WR: begin
        addr_d = addr_q + 1'b1;
        rem_d  = rem_q - 1'b1;
        if (rem_d == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          mem_wr_d   = 1'b0;
          mem_addr_d = addr_d;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign done      = done_q;
  assign rd_data   = rd_data_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd_   = mem_rd_q;
  assign mem_wr_   = mem_wr_q;

endmodule

// File: tb/tb_ram_mover.sv
// Directed bench for ram_mover paired with a 256x8 RAM model
// (combinational read, posedge write).
module tb_ram_mover;
  import ram_mover_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr, req_dst, req_data, req_len;
  logic       done;
  logic [7:0] rd_data, mem_addr, mem_wdata, mem_rdata;
  logic       mem_rd_, mem_wr_;

  logic [7:0] ram [256];
  logic       ram_init;
  int         tests = 0;
  int         fails = 0;
  int         both_low = 0;
  int         strobe_cnt = 0;
  int         wr80_cnt = 0;

  ram_mover dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_dst   (req_dst),
    .req_data  (req_data),
    .req_len   (req_len),
    .done      (done),
    .rd_data   (rd_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_rd_   (mem_rd_),
    .mem_wr_   (mem_wr_)
  );

  always #5 clk = ~clk;

  // RAM model; the init pattern is ram[i] = i ^ 0xC3
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'hC3;
    end else if (!mem_wr_) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (!mem_wr_ && mem_addr == 8'h80) wr80_cnt <= wr80_cnt + 1;
  end

  always @(negedge clk) begin
    if (!mem_rd_ && !mem_wr_) both_low <= both_low + 1;
    if (!mem_rd_ || !mem_wr_) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] data, input logic [7:0] len);
    int g = 0;
    while (!req_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    req_op = op; req_addr = a; req_dst = d; req_data = data; req_len = len;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; the accept edge itself counts as 1.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 600) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] data, input logic [7:0] len,
                         input int exp_lat);
    int lat;
    issue(op, a, d, data, len);
    wait_done(lat);
    check({tag, " latency"}, lat, exp_lat);
    @(posedge clk); #1;
    check({tag, " done one cycle"}, done, 1'b0);
  endtask

  initial begin
    int n, lat, s0;
    req_valid = 1'b0;
    req_op = '0; req_addr = '0; req_dst = '0; req_data = '0; req_len = '0;
    ram_init = 1'b1;

    #1 rst = 1'b1;
    #1;
    check("reset mem_rd_", mem_rd_, 1'b1);
    check("reset mem_wr_", mem_wr_, 1'b1);
    check("reset mem_addr", mem_addr, 8'h00);
    check("reset mem_wdata", mem_wdata, 8'h00);
    check("reset rd_data", rd_data, 8'h00);
    check("reset done", done, 1'b0);
    repeat (2) @(posedge clk);
    #1 ram_init = 1'b0;
    @(negedge clk) rst = 1'b0;
    #1 check("reset req_ready", req_ready, 1'b1);
    @(posedge clk); #1;

    // single write then read back
    run_cmd("write 10", OP_WRITE, 8'h10, 8'h00, 8'hA5, 8'h00, 2);
    check("write ram[10]", ram[8'h10], 8'hA5);
    run_cmd("read 10", OP_READ, 8'h10, 8'h00, 8'h00, 8'h00, 2);
    check("read rd_data", rd_data, 8'hA5);

    // fill with address wrap
    run_cmd("fill FE", OP_FILL, 8'hFE, 8'h00, 8'h3C, 8'd4, 5);
    check("fill ram[FE]", ram[8'hFE], 8'h3C);
    check("fill ram[FF]", ram[8'hFF], 8'h3C);
    check("fill ram[00]", ram[8'h00], 8'h3C);
    check("fill ram[01]", ram[8'h01], 8'h3C);
    check("fill ram[02] untouched", ram[8'h02], 8'hC1);
    check("fill keeps rd_data", rd_data, 8'hA5);

    // copy 3 bytes
    run_cmd("src 20", OP_WRITE, 8'h20, 8'h00, 8'h11, 8'h00, 2);
    run_cmd("src 21", OP_WRITE, 8'h21, 8'h00, 8'h22, 8'h00, 2);
    run_cmd("src 22", OP_WRITE, 8'h22, 8'h00, 8'h33, 8'h00, 2);
    run_cmd("copy 20->40", OP_COPY, 8'h20, 8'h40, 8'h00, 8'd3, 7);
    check("copy ram[40]", ram[8'h40], 8'h11);
    check("copy ram[41]", ram[8'h41], 8'h22);
    check("copy ram[42]", ram[8'h42], 8'h33);
    check("copy ram[43] untouched", ram[8'h43], 8'h80);
    check("copy keeps rd_data", rd_data, 8'hA5);

    // zero-length commands
    s0 = strobe_cnt;
    run_cmd("fill len0", OP_FILL, 8'h50, 8'h00, 8'hFF, 8'd0, 1);
    check("fill len0 strobes", strobe_cnt - s0, 0);
    check("fill len0 ram[50]", ram[8'h50], 8'h93);
    s0 = strobe_cnt;
    run_cmd("copy len0", OP_COPY, 8'h20, 8'h60, 8'h00, 8'd0, 1);
    check("copy len0 strobes", strobe_cnt - s0, 0);
    check("copy len0 ram[60]", ram[8'h60], 8'hA3);

    // request held while busy
    issue(OP_COPY, 8'h40, 8'h70, 8'h00, 8'd2);
    req_op = OP_WRITE; req_addr = 8'h80; req_data = 8'h77; req_len = 8'd0;
    req_valid = 1'b1;
    check("busy req_ready", req_ready, 1'b0);
    n = 1;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy copy latency", n, 5);
    check("busy ready in DONE", req_ready, 1'b0);
    check("busy no early write", wr80_cnt, 0);
    @(posedge clk); #1;
    check("busy ready after DONE", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_done(lat);
    check("held write latency", lat, 2);
    @(posedge clk); #1;
    check("busy copy ram[70]", ram[8'h70], 8'h11);
    check("busy copy ram[71]", ram[8'h71], 8'h22);
    check("held write ram[80]", ram[8'h80], 8'h77);
    check("held write once", wr80_cnt, 1);

    // reset in the middle of a fill
    issue(OP_FILL, 8'h90, 8'h00, 8'h5E, 8'd8);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort mem_wr_", mem_wr_, 1'b1);
    check("abort mem_rd_", mem_rd_, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort no done", done, 1'b0);
    end
    @(negedge clk) rst = 1'b0;
    #1 check("abort req_ready", req_ready, 1'b1);
    check("abort ram[90]", ram[8'h90], 8'h5E);
    check("abort ram[91]", ram[8'h91], 8'h5E);
    check("abort ram[92]", ram[8'h92], 8'h5E);
    check("abort ram[93] untouched", ram[8'h93], 8'h50);

    check("strobes never both low", both_low, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
